// File: rtl/cache_control_if.sv
// cache_control_if: CPU-side and physical-memory-side handshake signals of the
// two-way cache controller.
//
// Signals:
//   mem_read, mem_write : CPU read / write request (level, held until mem_resp)
//   mem_resp            : request complete (single-cycle pulse from controller)
//   pmem_read           : controller asks memory for a block fill
//   pmem_write          : controller asks memory to accept a dirty victim block
//   pmem_resp           : memory reports the current transaction done
//
// Handshake: a CPU request is a level held until the cycle mem_resp=1. A memory
// transaction is a level on pmem_read or pmem_write held until the cycle
// pmem_resp=1; that cycle completes it. Only one of pmem_read/pmem_write is high
// at any time.
//
// Modports:
//   slave  : the controller (receives CPU requests, drives memory requests)
//   master : the environment (issues CPU requests, plays the memory)
interface cache_control_if;
    logic mem_read;
    logic mem_write;
    logic mem_resp;
    logic pmem_read;
    logic pmem_write;
    logic pmem_resp;

    modport slave (
        input  mem_read,
        input  mem_write,
        input  pmem_resp,
        output mem_resp,
        output pmem_read,
        output pmem_write
    );

    modport master (
        output mem_read,
        output mem_write,
        output pmem_resp,
        input  mem_resp,
        input  pmem_read,
        input  pmem_write
    );
endinterface

// File: rtl/cache_control.sv
// cache_control: control FSM for a two-way set-associative write-back cache.
// Hits complete in the cycle they are presented. A miss latches the LRU way as
// victim, writes it back to memory if dirty, fills it from memory, then returns
// to IDLE where the still-pending request completes as a hit.
//
// Ports:
//   clk, reset        : clock, synchronous active-high reset
//   bus (slave)       : CPU request/response and physical memory handshake
//   ishit0_out/1_out  : tag match per way
//   dirtyarr0/1_out   : dirty bit per way
//   lru_out           : victim way (1 = way1)
//   datainmux_sel     : 0 = pmem block, 1 = CPU-merged block
//   *_write           : datapath array write enables
//   addressmux_sel    : 00 CPU addr, 01 way0 writeback addr, 10 way1 writeback addr
//   hit_count, miss_count, wb_count : wrapping 16-bit statistics
//   state_dbg         : current FSM state (0 IDLE, 1 WRITEBACK, 2 ALLOCATE)
module cache_control (
    input  logic            clk,
    input  logic            reset,
    cache_control_if.slave  bus,
    input  logic            ishit0_out,
    input  logic            ishit1_out,
    input  logic            dirtyarr0_out,
    input  logic            dirtyarr1_out,
    input  logic            lru_out,
    output logic            datainmux_sel,
    output logic            dataarr0_write,
    output logic            dataarr1_write,
    output logic            valid0_write,
    output logic            valid1_write,
    output logic            tag0_write,
    output logic            tag1_write,
    output logic            dirtyarr0_write,
    output logic            dirtyarr1_write,
    output logic            lru_write,
    output logic [1:0]      addressmux_sel,
    output logic [15:0]     hit_count,
    output logic [15:0]     miss_count,
    output logic [15:0]     wb_count,
    output logic [1:0]      state_dbg
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WRITEBACK = 2'd1,
        ALLOCATE  = 2'd2
    } state_t;

    state_t state;
    state_t next_state;
    logic   victim;

    logic req;
    logic hit;

    // Ungated control values; the gating below keeps everything quiet while
    // reset is high so nothing is written into the arrays during reset.
    logic resp_c, pmem_read_c, pmem_write_c;
    logic data0_c, data1_c, valid0_c, valid1_c, tag0_c, tag1_c;
    logic dirty0_c, dirty1_c, lru_c;
    logic hit_evt, miss_evt, wb_evt;

    assign req = bus.mem_read | bus.mem_write;
    assign hit = ishit0_out | ishit1_out;

    always_comb begin
        next_state     = state;
        resp_c         = 1'b0;
        pmem_read_c    = 1'b0;
        pmem_write_c   = 1'b0;
        datainmux_sel  = 1'b0;
        addressmux_sel = 2'b00;
        data0_c        = 1'b0;
        data1_c        = 1'b0;
        valid0_c       = 1'b0;
        valid1_c       = 1'b0;
        tag0_c         = 1'b0;
        tag1_c         = 1'b0;
        dirty0_c       = 1'b0;
        dirty1_c       = 1'b0;
        lru_c          = 1'b0;
        hit_evt        = 1'b0;
        miss_evt       = 1'b0;
        wb_evt         = 1'b0;

        case (state)
            IDLE: begin
                if (req) begin
                    if (hit) begin
                        resp_c  = 1'b1;
                        lru_c   = 1'b1;
                        hit_evt = 1'b1;
                        // A write (also read+write together) merges CPU data
                        // into the hitting way; way0 wins if both match.
                        if (bus.mem_write) begin
                            datainmux_sel = 1'b1;
                            if (ishit0_out) begin
                                data0_c  = 1'b1;
                                dirty0_c = 1'b1;
                            end else begin
                                data1_c  = 1'b1;
                                dirty1_c = 1'b1;
                            end
                        end
                    end else begin
                        miss_evt = 1'b1;
                        if (lru_out ? dirtyarr1_out : dirtyarr0_out)
                            next_state = WRITEBACK;
                        else
                            next_state = ALLOCATE;
                    end
                end
            end

            WRITEBACK: begin
                pmem_write_c   = 1'b1;
                addressmux_sel = victim ? 2'b10 : 2'b01;
                if (bus.pmem_resp) begin
                    wb_evt     = 1'b1;
                    next_state = ALLOCATE;
                end
            end

            ALLOCATE: begin
                pmem_read_c = 1'b1;
                if (bus.pmem_resp) begin
                    // Fill the latched victim; the dirty enable is pulsed with
                    // the pmem mux selected, so the fresh block loads clean.
                    if (victim) begin
                        data1_c  = 1'b1;
                        tag1_c   = 1'b1;
                        valid1_c = 1'b1;
                        dirty1_c = 1'b1;
                    end else begin
                        data0_c  = 1'b1;
                        tag0_c   = 1'b1;
                        valid0_c = 1'b1;
                        dirty0_c = 1'b1;
                    end
                    next_state = IDLE;
                end
            end

            default: next_state = IDLE;
        endcase
    end

    assign bus.mem_resp    = resp_c       & ~reset;
    assign bus.pmem_read   = pmem_read_c  & ~reset;
    assign bus.pmem_write  = pmem_write_c & ~reset;
    assign dataarr0_write  = data0_c      & ~reset;
    assign dataarr1_write  = data1_c      & ~reset;
    assign valid0_write    = valid0_c     & ~reset;
    assign valid1_write    = valid1_c     & ~reset;
    assign tag0_write      = tag0_c       & ~reset;
    assign tag1_write      = tag1_c       & ~reset;
    assign dirtyarr0_write = dirty0_c     & ~reset;
    assign dirtyarr1_write = dirty1_c     & ~reset;
    assign lru_write       = lru_c        & ~reset;
    assign state_dbg       = state;

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            victim     <= 1'b0;
            hit_count  <= 16'h0000;
            miss_count <= 16'h0000;
            wb_count   <= 16'h0000;
        end else begin
            state <= next_state;
            // Victim only changes on a fresh miss, so lru_out movement during
            // WRITEBACK/ALLOCATE cannot redirect the fill.
            if (miss_evt)
                victim <= lru_out;
            if (hit_evt)
                hit_count <= hit_count + 16'd1;
            if (miss_evt)
                miss_count <= miss_count + 16'd1;
            if (wb_evt)
                wb_count <= wb_count + 16'd1;
        end
    end

endmodule

// File: tb/tb_cache_control.sv
module tb_cache_control;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WB   = 2'd1;
    localparam logic [1:0] S_ALLO = 2'd2;

    // Control word layout used for comparisons.
    localparam logic [14:0] C_RESP = 15'h4000;
    localparam logic [14:0] C_PRD  = 15'h2000;
    localparam logic [14:0] C_PWR  = 15'h1000;
    localparam logic [14:0] C_DMUX = 15'h0800;
    localparam logic [14:0] C_D0   = 15'h0400;
    localparam logic [14:0] C_D1   = 15'h0200;
    localparam logic [14:0] C_V0   = 15'h0100;
    localparam logic [14:0] C_V1   = 15'h0080;
    localparam logic [14:0] C_T0   = 15'h0040;
    localparam logic [14:0] C_T1   = 15'h0020;
    localparam logic [14:0] C_Y0   = 15'h0010;
    localparam logic [14:0] C_Y1   = 15'h0008;
    localparam logic [14:0] C_LRU  = 15'h0004;
    localparam logic [14:0] C_A2   = 15'h0002;
    localparam logic [14:0] C_A1   = 15'h0001;
    localparam logic [14:0] FILL0  = C_D0 | C_V0 | C_T0 | C_Y0;
    localparam logic [14:0] FILL1  = C_D1 | C_V1 | C_T1 | C_Y1;
    localparam logic [14:0] ARRAYS = FILL0 | FILL1 | C_LRU;

    logic clk;
    logic reset;
    logic ishit0_out, ishit1_out, dirtyarr0_out, dirtyarr1_out, lru_out;
    logic datainmux_sel, dataarr0_write, dataarr1_write, valid0_write, valid1_write;
    logic tag0_write, tag1_write, dirtyarr0_write, dirtyarr1_write, lru_write;
    logic [1:0]  addressmux_sel;
    logic [15:0] hit_count, miss_count, wb_count;
    logic [1:0]  state_dbg;

    cache_control_if bus ();

    cache_control dut (
        .clk             (clk),
        .reset           (reset),
        .bus             (bus.slave),
        .ishit0_out      (ishit0_out),
        .ishit1_out      (ishit1_out),
        .dirtyarr0_out   (dirtyarr0_out),
        .dirtyarr1_out   (dirtyarr1_out),
        .lru_out         (lru_out),
        .datainmux_sel   (datainmux_sel),
        .dataarr0_write  (dataarr0_write),
        .dataarr1_write  (dataarr1_write),
        .valid0_write    (valid0_write),
        .valid1_write    (valid1_write),
        .tag0_write      (tag0_write),
        .tag1_write      (tag1_write),
        .dirtyarr0_write (dirtyarr0_write),
        .dirtyarr1_write (dirtyarr1_write),
        .lru_write       (lru_write),
        .addressmux_sel  (addressmux_sel),
        .hit_count       (hit_count),
        .miss_count      (miss_count),
        .wb_count        (wb_count),
        .state_dbg       (state_dbg)
    );

    // ---------------- clock ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- scoreboard ----------------
    int checks = 0;
    int errors = 0;
    logic [15:0] exp_hit, exp_miss, exp_wb;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [14:0] ctrl_word();
        return {bus.mem_resp, bus.pmem_read, bus.pmem_write, datainmux_sel,
                dataarr0_write, dataarr1_write, valid0_write, valid1_write,
                tag0_write, tag1_write, dirtyarr0_write, dirtyarr1_write,
                lru_write, addressmux_sel};
    endfunction

    task automatic chk_counts(input string tag);
        chk({tag, "_hit"},  {16'h0, hit_count},  {16'h0, exp_hit});
        chk({tag, "_miss"}, {16'h0, miss_count}, {16'h0, exp_miss});
        chk({tag, "_wb"},   {16'h0, wb_count},   {16'h0, exp_wb});
    endtask

    // ---------------- driver ----------------
    task automatic drive(input logic rd, input logic wr, input logic h0, input logic h1,
                         input logic d0, input logic d1, input logic lru, input logic presp);
        bus.mem_read   = rd;
        bus.mem_write  = wr;
        ishit0_out     = h0;
        ishit1_out     = h1;
        dirtyarr0_out  = d0;
        dirtyarr1_out  = d1;
        lru_out        = lru;
        bus.pmem_resp  = presp;
    endtask

    // Called at a negedge; returns at the following negedge with reset low.
    task automatic do_reset();
        reset = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        @(posedge clk);
        #1;
        @(negedge clk);
        reset = 1'b0;
        exp_hit  = 16'h0;
        exp_miss = 16'h0;
        exp_wb   = 16'h0;
    endtask

    // Sample after the edge that follows the current negedge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic        rd, wr, h0, h1, d0, d1, lru;
        logic [14:0] ctrl;
        logic [1:0]  nxt;
    } vec_t;

    vec_t vecs[12];

    initial begin
        vecs[0]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 15'h0, S_IDLE};
        vecs[1]  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, C_RESP | C_LRU, S_IDLE};
        vecs[2]  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, C_RESP | C_LRU, S_IDLE};
        vecs[3]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, C_RESP | C_LRU | C_DMUX | C_D0 | C_Y0, S_IDLE};
        vecs[4]  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, C_RESP | C_LRU | C_DMUX | C_D1 | C_Y1, S_IDLE};
        vecs[5]  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, C_RESP | C_LRU | C_DMUX | C_D0 | C_Y0, S_IDLE};
        vecs[6]  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, C_RESP | C_LRU | C_DMUX | C_D1 | C_Y1, S_IDLE};
        vecs[7]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 15'h0, S_ALLO};
        vecs[8]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 15'h0, S_WB};
        vecs[9]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 15'h0, S_WB};
        vecs[10] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 15'h0, S_ALLO};
        vecs[11] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 15'h0, S_IDLE};
    end

    // ---------------- test ----------------
    initial begin
        reset = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        exp_hit = 16'h0; exp_miss = 16'h0; exp_wb = 16'h0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_state", {30'h0, state_dbg}, {30'h0, S_IDLE});
        chk("rst_ctrl", {17'h0, ctrl_word()}, 32'h0);
        chk_counts("rst");
        @(negedge clk);
        reset = 1'b0;

        // Single-cycle IDLE decisions.
        for (int i = 0; i < 12; i++) begin
            drive(vecs[i].rd, vecs[i].wr, vecs[i].h0, vecs[i].h1,
                  vecs[i].d0, vecs[i].d1, vecs[i].lru, 1'b0);
            #1;
            chk($sformatf("vec%0d_ctrl", i), {17'h0, ctrl_word()}, {17'h0, vecs[i].ctrl});
            tick();
            chk($sformatf("vec%0d_state", i), {30'h0, state_dbg}, {30'h0, vecs[i].nxt});
            if (vecs[i].rd | vecs[i].wr) begin
                if (vecs[i].h0 | vecs[i].h1) exp_hit++;
                else exp_miss++;
            end
            chk_counts($sformatf("vec%0d", i));
            @(negedge clk);
            if (vecs[i].nxt != S_IDLE) do_reset();
        end

        // Clean miss on way0, lru_out toggling during ALLOCATE, then retry hit.
        drive(1, 0, 0, 0, 0, 0, 0, 0);
        #1;
        chk("clean_miss_ctrl", {17'h0, ctrl_word()}, 32'h0);
        tick();
        exp_miss++;
        chk("clean_miss_state", {30'h0, state_dbg}, {30'h0, S_ALLO});
        chk_counts("clean_miss");
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            drive(1, 0, 0, 0, 0, 0, ~k[0], 0);
            #1;
            chk($sformatf("alloc_wait%0d_ctrl", k), {17'h0, ctrl_word()}, {17'h0, C_PRD});
            tick();
            chk($sformatf("alloc_wait%0d_state", k), {30'h0, state_dbg}, {30'h0, S_ALLO});
        end
        @(negedge clk);
        drive(1, 0, 0, 0, 0, 0, 1, 1);
        #1;
        chk("alloc_fill0_ctrl", {17'h0, ctrl_word()}, {17'h0, C_PRD | FILL0});
        tick();
        chk("alloc_fill0_state", {30'h0, state_dbg}, {30'h0, S_IDLE});
        @(negedge clk);
        drive(1, 0, 1, 0, 0, 0, 1, 0);
        #1;
        chk("retry_hit_ctrl", {17'h0, ctrl_word()}, {17'h0, C_RESP | C_LRU});
        tick();
        exp_hit++;
        chk_counts("retry_hit");

        // Dirty miss on way1 with the request withdrawn during WRITEBACK.
        @(negedge clk);
        drive(1, 0, 0, 0, 0, 1, 1, 0);
        tick();
        exp_miss++;
        chk("dirty_miss_state", {30'h0, state_dbg}, {30'h0, S_WB});
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            drive(0, 0, 0, 0, 0, 1, k[0], 0);
            #1;
            chk($sformatf("wb_wait%0d_ctrl", k), {17'h0, ctrl_word()}, {17'h0, C_PWR | C_A2});
            tick();
            chk($sformatf("wb_wait%0d_state", k), {30'h0, state_dbg}, {30'h0, S_WB});
        end
        @(negedge clk);
        drive(0, 0, 0, 0, 0, 1, 0, 1);
        #1;
        chk("wb_done_ctrl", {17'h0, ctrl_word()}, {17'h0, C_PWR | C_A2});
        tick();
        exp_wb++;
        chk("wb_done_state", {30'h0, state_dbg}, {30'h0, S_ALLO});
        chk_counts("wb_done");
        @(negedge clk);
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        #1;
        chk("alloc1_wait_ctrl", {17'h0, ctrl_word()}, {17'h0, C_PRD});
        tick();
        @(negedge clk);
        drive(0, 0, 0, 0, 0, 0, 0, 1);
        #1;
        chk("alloc_fill1_ctrl", {17'h0, ctrl_word()}, {17'h0, C_PRD | FILL1});
        tick();
        chk("alloc_fill1_state", {30'h0, state_dbg}, {30'h0, S_IDLE});
        @(negedge clk);
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        #1;
        chk("idle_quiet_ctrl", {17'h0, ctrl_word()}, 32'h0);

        // Dirty miss on way0, then reset while in WRITEBACK.
        drive(0, 1, 0, 0, 1, 0, 0, 0);
        tick();
        exp_miss++;
        @(negedge clk);
        #1;
        chk("wb0_ctrl", {17'h0, ctrl_word()}, {17'h0, C_PWR | C_A1});
        reset = 1'b1;
        drive(0, 1, 0, 0, 1, 0, 0, 1);
        #1;
        chk("wb_rst_arrays", {17'h0, ctrl_word() & ARRAYS}, 32'h0);
        tick();
        exp_hit = 16'h0; exp_miss = 16'h0; exp_wb = 16'h0;
        chk("wb_rst_state", {30'h0, state_dbg}, {30'h0, S_IDLE});
        chk_counts("wb_rst");
        @(negedge clk);
        reset = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        #1;
        chk("wb_rst_after_ctrl", {17'h0, ctrl_word()}, 32'h0);

        // Reset while ALLOCATE sees pmem_resp: no fill may be written.
        drive(1, 0, 0, 0, 0, 0, 1, 0);
        tick();
        @(negedge clk);
        reset = 1'b1;
        drive(1, 0, 0, 0, 0, 0, 1, 1);
        #1;
        chk("alloc_rst_arrays", {17'h0, ctrl_word() & ARRAYS}, 32'h0);
        tick();
        chk("alloc_rst_state", {30'h0, state_dbg}, {30'h0, S_IDLE});
        @(negedge clk);
        reset = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        #1;
        chk("alloc_rst_after_ctrl", {17'h0, ctrl_word()}, 32'h0);

        // Hit counter wrap: 65535 hits reach FFFF, one more wraps to 0.
        drive(1, 0, 0, 1, 0, 0, 0, 0);
        repeat (65535) @(posedge clk);
        #1;
        chk("hit_ffff", {16'h0, hit_count}, 32'h0000FFFF);
        tick();
        chk("hit_wrap", {16'h0, hit_count}, 32'h0);
        chk("wrap_miss", {16'h0, miss_count}, 32'h0);
        @(negedge clk);
        drive(0, 0, 0, 0, 0, 0, 0, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/cache_control.md
CACHE_CONTROL -- requirements
Module: cache_control

Interface
REQ-001 SHALL have ports: clk in 1, clock; reset in 1, synchronous active-high reset.
REQ-002 SHALL have CPU ports: mem_read in 1, read request; mem_write in 1, write request; mem_resp out 1, request complete.
REQ-003 SHALL have physical memory ports: pmem_read out 1; pmem_write out 1; pmem_resp in 1, transaction done.
REQ-004 SHALL have datapath status inputs, 1 bit each: ishit0_out, ishit1_out, dirtyarr0_out, dirtyarr1_out, lru_out (1 = way1 is victim).
REQ-005 SHALL have datapath control outputs, 1 bit each: datainmux_sel (0 = pmem block, 1 = merged CPU block), dataarr0_write, dataarr1_write, valid0_write, valid1_write, tag0_write, tag1_write, dirtyarr0_write, dirtyarr1_write, lru_write.
REQ-006 SHALL have addressmux_sel out 2: 00 = CPU address, 01 = way0 writeback address, 10 = way1 writeback address; 11 never driven.
REQ-007 SHALL have 16-bit statistics outputs: hit_count, miss_count, wb_count.

Function
REQ-008 SHALL implement FSM states IDLE, WRITEBACK, ALLOCATE; control outputs are combinational from state and inputs.
REQ-009 SHALL treat req = mem_read | mem_write; with both high, write behaviour applies.
REQ-010 IDLE, req and (ishit0_out | ishit1_out): mem_resp=1 same cycle, lru_write=1, stay IDLE, hit_count+1.
REQ-011 IDLE write hit: additionally datainmux_sel=1, dataarrN_write=1 and dirtyarrN_write=1 for the hit way only (way0 if both hit).
REQ-012 IDLE, req and no hit: mem_resp=0; latch victim = lru_out; miss_count+1; next state WRITEBACK if the victim's dirty bit=1, else ALLOCATE.
REQ-013 WRITEBACK: pmem_write=1, addressmux_sel = 01 (victim 0) or 10 (victim 1); hold until pmem_resp=1, then wb_count+1 and go to ALLOCATE.
REQ-014 ALLOCATE: pmem_read=1, addressmux_sel=00, datainmux_sel=0; hold until pmem_resp=1.
REQ-015 ALLOCATE with pmem_resp=1: dataarrV_write, tagV_write, validV_write, dirtyarrV_write=1 for latched victim V only; next state IDLE; mem_resp stays 0.
REQ-016 The cycle after ALLOCATE the retried request is re-evaluated in IDLE and completes as a hit (REQ-010/011).
REQ-017 pmem_read and pmem_write SHALL never both be high; neither is high in IDLE.
REQ-018 Withdrawal of req during WRITEBACK/ALLOCATE SHALL NOT abort the memory transaction; FSM completes and returns to IDLE.
REQ-019 The latched victim SHALL be held constant for the whole miss sequence, regardless of lru_out changes.
REQ-020 Counters wrap 16'hFFFF -> 16'h0000; each increments at most once per cycle.
REQ-021 All write enables, mem_resp, pmem_read, pmem_write SHALL be 0 whenever not required by REQ-010..015.

Reset
REQ-022 reset=1 at a clk edge: state=IDLE, victim=0, all counters=0, effective next cycle; reset overrides any transition.
REQ-023 Reset mid-WRITEBACK/ALLOCATE: pmem_read/pmem_write low from the cycle after reset is sampled; no array write enables asserted while reset is high.

Verification
REQ-024 Read hit: IDLE, mem_read=1, ishit1_out=1 -> mem_resp=1 same cycle, lru_write=1, no data writes, hit_count 0->1.
REQ-025 Write hit way0: mem_write=1, ishit0_out=1 -> datainmux_sel=1, dataarr0_write=1, dirtyarr0_write=1, mem_resp=1, way1 enables 0.
REQ-026 Clean miss: mem_read=1, no hit, lru_out=0, dirtyarr0_out=0 -> ALLOCATE, pmem_read=1, addressmux_sel=00; pmem_resp after 5 cycles -> dataarr0/tag0/valid0/dirtyarr0_write pulse 1 cycle, IDLE, miss_count=1.
REQ-027 Dirty miss: lru_out=1, dirtyarr1_out=1 -> WRITEBACK, pmem_write=1, addressmux_sel=10 until pmem_resp; then ALLOCATE; wb_count=1; way1 enables on fill.
REQ-028 Victim stability: toggle lru_out during ALLOCATE -> fill still targets latched way.
REQ-029 Reset in WRITEBACK -> next cycle IDLE, pmem_write=0, counters=0; hit_count preset to 16'hFFFF plus one hit -> 16'h0000.
